// File: rtl/logic_slice40_pkg.sv
// ----------------------------------------------------------------------------
// logic_slice40_pkg
// Shared constants and types for the logic_slice40 block.
//   LUT_W       : bits per look-up table (4-input LUT -> 16 entries)
//   IDX_W       : width of the configuration cell index
//   SEL_W       : LUT select width (four inputs)
//   cfg_state_t : configuration FSM states
//   majority3   : carry-chain majority function
// ----------------------------------------------------------------------------
package logic_slice40_pkg;

    localparam int LUT_W = 16;
    localparam int IDX_W = 5;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        CFG_IDLE   = 2'd0,
        CFG_COMMIT = 2'd1,
        CFG_DONE   = 2'd2
    } cfg_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/lc_cell40.sv
// ----------------------------------------------------------------------------
// lc_cell40
// One logic cell: a 4-input LUT, a carry-chain majority stage, an output
// register with synchronous set/reset and clock enable, and an output mux
// choosing registered or combinational LUT output.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   lut[15:0]         active LUT contents for this cell
//   in0..in3          LUT inputs (in3 replaced by carry_in when C_ON=1)
//   carry_in          carry from the previous cell
//   ce, sr            register clock enable, synchronous load of SR_VAL
//   carry_out         carry to the next cell
//   ltout             raw LUT output
//   lcout             cell output (registered when REG_EN=1)
// ----------------------------------------------------------------------------
module lc_cell40
    import logic_slice40_pkg::*;
#(
    parameter bit C_ON   = 1'b1,
    parameter bit REG_EN = 1'b1,
    parameter bit SR_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LUT_W-1:0] lut,
    input  logic             in0,
    input  logic             in1,
    input  logic             in2,
    input  logic             in3,
    input  logic             carry_in,
    input  logic             ce,
    input  logic             sr,
    output logic             carry_out,
    output logic             ltout,
    output logic             lcout
);

    logic [SEL_W-1:0] sel;
    logic             q;

    assign sel       = {(C_ON ? carry_in : in3), in2, in1, in0};
    assign ltout     = lut[sel];
    assign carry_out = majority3(in1, in2, carry_in);

    // NOTE: state is written with non-blocking assignments so every flop in
    // the slice samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SR_VAL;
        end else if (sr) begin
            q <= SR_VAL;
        end else if (ce) begin
            q <= ltout;
        end
    end

    assign lcout = REG_EN ? q : ltout;

endmodule

// File: rtl/logic_slice40.sv
// ----------------------------------------------------------------------------
// logic_slice40
// A slice of NUM_LC logic cells sharing a carry chain, plus a shadow LUT
// configuration channel. LUTs are written into shadow storage one at a time
// and copied into the active LUTs in a single edge on commit, so no cell ever
// evaluates with a mix of old and new contents.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in0..in3 [NUM_LC]     per-cell LUT inputs
//   carryin / carryout    carry into cell 0 / out of the last cell
//   ce, sr                register enable, synchronous load of SR_VAL
//   lcout, ltout          cell outputs, raw LUT outputs
//   cfg_valid/ready/idx/lut  shadow LUT write channel
//   cfg_commit            request shadow-to-active copy
//   cfg_done, cfg_err     one-cycle commit-complete / bad-index pulses
// ----------------------------------------------------------------------------
module logic_slice40
    import logic_slice40_pkg::*;
#(
    parameter int                      NUM_LC   = 8,
    parameter logic [NUM_LC*LUT_W-1:0] LUT_INIT = '0,
    parameter bit                      C_ON     = 1'b1,
    parameter logic [NUM_LC-1:0]       REG_EN   = '1,
    parameter logic [NUM_LC-1:0]       SR_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_LC-1:0] in0,
    input  logic [NUM_LC-1:0] in1,
    input  logic [NUM_LC-1:0] in2,
    input  logic [NUM_LC-1:0] in3,
    input  logic              carryin,
    input  logic              ce,
    input  logic              sr,
    output logic [NUM_LC-1:0] lcout,
    output logic [NUM_LC-1:0] ltout,
    output logic              carryout,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [LUT_W-1:0]  cfg_lut,
    input  logic              cfg_commit,
    output logic              cfg_done,
    output logic              cfg_err
);

    cfg_state_t       state_q, state_d;
    logic [LUT_W-1:0] shadow_q [NUM_LC];
    logic [LUT_W-1:0] active_q [NUM_LC];
    logic             err_q;
    logic             idx_ok;
    logic             wr_ok;
    logic             wr_bad;
    logic             copy;
    logic [NUM_LC:0]  carry;

    // ---------------- configuration FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CFG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        cfg_done  = 1'b0;
        unique case (state_q)
            CFG_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_commit) state_d = CFG_COMMIT;
            end
            CFG_COMMIT: state_d = CFG_DONE;
            CFG_DONE: begin
                cfg_done = 1'b1;
                state_d  = CFG_IDLE;
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    // Index compared one bit wider so NUM_LC = 32 does not overflow.
    assign idx_ok = ({1'b0, cfg_idx} < (IDX_W + 1)'(NUM_LC));
    assign wr_ok  = cfg_valid & cfg_ready & idx_ok;
    assign wr_bad = cfg_valid & cfg_ready & ~idx_ok;
    assign copy   = (state_q == CFG_COMMIT);

    // ---------------- shadow / active LUT storage ----------------
    // NOTE: these small LUT arrays are reset because reset must restore the
    // power-on configuration; a data-path RAM would normally be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LC; i++) begin
                shadow_q[i] <= LUT_INIT[i*LUT_W +: LUT_W];
                active_q[i] <= LUT_INIT[i*LUT_W +: LUT_W];
            end
        end else begin
            for (int i = 0; i < NUM_LC; i++) begin
                if (wr_ok && (cfg_idx == IDX_W'(i))) begin
                    shadow_q[i] <= cfg_lut;
                end
                // Whole-array copy in one edge: new LUTs appear together.
                if (copy) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= wr_bad;
        end
    end

    assign cfg_err = err_q;

    // ---------------- logic cells ----------------
    assign carry[0] = carryin;

    for (genvar g = 0; g < NUM_LC; g++) begin : g_cell
        lc_cell40 #(
            .C_ON   (C_ON),
            .REG_EN (REG_EN[g]),
            .SR_VAL (SR_VAL[g])
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .lut       (active_q[g]),
            .in0       (in0[g]),
            .in1       (in1[g]),
            .in2       (in2[g]),
            .in3       (in3[g]),
            .carry_in  (carry[g]),
            .ce        (ce),
            .sr        (sr),
            .carry_out (carry[g+1]),
            .ltout     (ltout[g]),
            .lcout     (lcout[g])
        );
    end

    // Without the carry chain feeding the LUTs the chain output is forced low.
    assign carryout = C_ON ? carry[NUM_LC] : 1'b0;

endmodule

// File: tb/tb_logic_slice40.sv
// ----------------------------------------------------------------------------
// tb_logic_slice40
// Self-checking bench for logic_slice40 with NUM_LC=4, all LUTs XOR4,
// carry chain on, all cells registered, SR_VAL=4'b1010.
// ----------------------------------------------------------------------------
module tb_logic_slice40;

    localparam int          N     = 4;
    localparam logic [15:0] XOR4  = 16'h6996;
    localparam logic [3:0]  SRV   = 4'b1010;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic         carryin = 1'b0, ce = 1'b0, sr = 1'b0;
    logic [N-1:0] lcout, ltout;
    logic         carryout;
    logic         cfg_valid = 1'b0, cfg_commit = 1'b0;
    logic         cfg_ready, cfg_done, cfg_err;
    logic [4:0]   cfg_idx = '0;
    logic [15:0]  cfg_lut = '0;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit chk_en   = 1'b0;

    logic_slice40 #(
        .NUM_LC   (N),
        .LUT_INIT ({N{XOR4}}),
        .C_ON     (1'b1),
        .REG_EN   ({N{1'b1}}),
        .SR_VAL   (SRV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .carryin    (carryin),
        .ce         (ce),
        .sr         (sr),
        .lcout      (lcout),
        .ltout      (ltout),
        .carryout   (carryout),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idx    (cfg_idx),
        .cfg_lut    (cfg_lut),
        .cfg_commit (cfg_commit),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Carry into cell i is the carry out of the i-bit sum in1+in2+carryin.
    function automatic logic [N-1:0] model_lt(input logic [N-1:0] a0, input logic [N-1:0] a1,
                                              input logic [N-1:0] a2, input logic c,
                                              input logic [15:0] act [N]);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            int   s;
            logic ci;
            logic [3:0] sel;
            s   = (int'(a1) % (1 << i)) + (int'(a2) % (1 << i)) + int'(c);
            ci  = ((s >> i) & 1) != 0;
            sel = {ci, a2[i], a1[i], a0[i]};
            r[i] = act[i][sel];
        end
        return r;
    endfunction

    function automatic logic model_cout(input logic [N-1:0] a1, input logic [N-1:0] a2, input logic c);
        return (((int'(a1) + int'(a2) + int'(c)) >> N) & 1) != 0;
    endfunction

    logic [15:0] m_active [N];
    logic [15:0] m_shadow [N];
    logic [N-1:0] m_q;
    int          m_age;     // cycles since an accepted commit: 0 idle, 1, 2 = done
    logic        m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_active[i] <= XOR4;
                m_shadow[i] <= XOR4;
            end
            m_q   <= SRV;
            m_age <= 0;
            m_err <= 1'b0;
        end else begin
            if (m_age == 0 && cfg_valid && int'(cfg_idx) < N) m_shadow[int'(cfg_idx) % N] <= cfg_lut;
            m_err <= (m_age == 0) && cfg_valid && int'(cfg_idx) >= N;
            if (m_age == 1) m_active <= m_shadow;
            m_age <= (m_age == 0) ? (cfg_commit ? 1 : 0) : (m_age == 1 ? 2 : 0);
            if (sr) m_q <= SRV;
            else if (ce) m_q <= model_lt(in0, in1, in2, carryin, m_active);
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("ltout",     32'(ltout),     32'(model_lt(in0, in1, in2, carryin, m_active)));
            check("lcout",     32'(lcout),     32'(m_q));
            check("carryout",  32'(carryout),  32'(model_cout(in1, in2, carryin)));
            check("cfg_ready", 32'(cfg_ready), 32'(m_age == 0));
            check("cfg_done",  32'(cfg_done),  32'(m_age == 2));
            check("cfg_err",   32'(cfg_err),   32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_done",  32'(cfg_done),  32'd0);
        check("rst_err",   32'(cfg_err),   32'd0);
        check("rst_lcout", 32'(lcout),     32'(4'b1010));

        // Adder-parity: F + 1 + 0 = 0x10 -> sum bits 0000, carry out 1.
        in0 = 4'h0; in1 = 4'hF; in2 = 4'h1; carryin = 1'b0;
        #1;
        check("add_f1_lt",   32'(ltout),    32'(4'b0000));
        check("add_f1_cout", 32'(carryout), 32'd1);
        // 5 + 3 + 1 = 9 -> sum bits 1001, carry out 0.
        in1 = 4'h5; in2 = 4'h3; carryin = 1'b1;
        #1;
        check("add_53_lt",   32'(ltout),    32'(4'b1001));
        check("add_53_cout", 32'(carryout), 32'd0);
        in0 = 4'hF;
        #1;
        check("add_53_inv",  32'(ltout),    32'(4'b0110));

        // Register load, sr priority, hold.
        ce = 1'b1;
        step();
        check("ce_load", 32'(lcout), 32'(4'b0110));
        ce = 1'b0; sr = 1'b1;
        step();
        check("sr_load", 32'(lcout), 32'(4'b1010));
        sr = 1'b0; in0 = 4'h0;
        step();
        check("hold", 32'(lcout), 32'(4'b1010));
        ce = 1'b1; sr = 1'b1;
        step();
        check("sr_over_ce", 32'(lcout), 32'(4'b1010));
        sr = 1'b0;
        step();
        check("ce_load2", 32'(lcout), 32'(4'b1001));

        // Shadow write without commit leaves active LUTs alone.
        cfg_valid = 1'b1; cfg_idx = 5'd2; cfg_lut = 16'hFFFF;
        step();
        cfg_valid = 1'b0;
        step();
        check("shadow_only", 32'(ltout), 32'(4'b1001));
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        check("commit_busy",  32'(cfg_ready), 32'd0);
        check("commit_old",   32'(ltout),     32'(4'b1001));
        step();
        check("done_pulse",   32'(cfg_done),  32'd1);
        check("done_new_lut", 32'(ltout),     32'(4'b1101));
        step();
        check("done_clear",   32'(cfg_done),  32'd0);

        // Write and commit requests outside IDLE are ignored.
        cfg_commit = 1'b1;
        step();
        cfg_valid = 1'b1; cfg_idx = 5'd0; cfg_lut = 16'h0000;
        step();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        step();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        step();
        check("busy_write_ignored", 32'(ltout), 32'(4'b1101));
        step();

        // Out-of-range index: one-cycle error, no shadow change.
        cfg_valid = 1'b1; cfg_idx = 5'd7; cfg_lut = 16'h0000;
        step();
        cfg_valid = 1'b0;
        check("err_pulse", 32'(cfg_err), 32'd1);
        step();
        check("err_clear", 32'(cfg_err), 32'd0);
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        step();
        check("err_no_write", 32'(ltout), 32'(4'b1101));
        step();

        // Write in the same cycle as commit is included.
        cfg_valid = 1'b1; cfg_idx = 5'd1; cfg_lut = 16'hFFFF; cfg_commit = 1'b1;
        step();
        cfg_valid = 1'b0; cfg_commit = 1'b0;
        step();
        check("same_cycle_done", 32'(cfg_done), 32'd1);
        check("same_cycle_lut",  32'(ltout),    32'(4'b1111));
        step();

        // Reset during COMMIT aborts and restores LUT_INIT.
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("abort_lut",   32'(ltout),   32'(4'b1001));
        check("abort_lcout", 32'(lcout),   32'(4'b1010));
        step();
        check("abort_nodone", 32'(cfg_done), 32'd0);
        rst = 1'b0;
        step();
        check("abort_ready", 32'(cfg_ready), 32'd1);
        check("abort_done2", 32'(cfg_done),  32'd0);
        check("abort_lut2",  32'(ltout),     32'(4'b1001));

        // A few more operand patterns through the registered path.
        for (int v = 0; v < 6; v++) begin
            in0 = 4'(v * 3); in1 = 4'(v * 5 + 2); in2 = 4'(15 - v * 2); carryin = v[0];
            step();
        end
        step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/logic_slice40.md
LOGIC_SLICE40 -- requirements
Module: logic_slice40

Interface
REQ-001 Parameter NUM_LC, default 8, number of logic cells in the slice (1..32).
REQ-002 Parameter LUT_INIT, default all-zero (NUM_LC*16 bits), power-on/reset LUT contents; cell i uses bits [16i+15:16i].
REQ-003 Parameter C_ON, default 1, 1 = carry chain drives LUT input 3 of every cell.
REQ-004 Parameter REG_EN, default all-ones (NUM_LC bits), 1 = cell lcout is registered, 0 = combinational.
REQ-005 Parameter SR_VAL, default all-zero (NUM_LC bits), value loaded into cell register by sr and by rst.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 in0, in1, in2, in3  in  NUM_LC each  per-cell LUT inputs.
REQ-009 carryin  in  1  carry into cell 0.
REQ-010 ce  in  1  register clock enable; sr  in  1  synchronous set/reset to SR_VAL.
REQ-011 lcout  out  NUM_LC  cell outputs; ltout  out  NUM_LC  raw LUT outputs; carryout  out  1  carry out of cell NUM_LC-1.
REQ-012 cfg_valid  in  1; cfg_ready  out  1; cfg_idx  in  5; cfg_lut  in  16  shadow-LUT write channel.
REQ-013 cfg_commit  in  1  request atomic shadow-to-active copy; cfg_done  out  1  one-cycle commit pulse; cfg_err  out  1  one-cycle bad-index pulse.

Function
REQ-014 LUT index = {i3, in2[i], in1[i], in0[i]}, i3 = carry[i] when C_ON=1 else in3[i]; ltout[i] = active_lut[i][index], combinational.
REQ-015 carry[0] = carryin; carry[i+1] = majority(in1[i], in2[i], carry[i]); carryout = carry[NUM_LC]; with C_ON=0 carryout SHALL be 0.
REQ-016 Register update priority per edge: sr -> q = SR_VAL[i]; else ce -> q = ltout[i]; else hold; sr SHALL act regardless of ce.
REQ-017 lcout[i] = q[i] when REG_EN[i]=1 (one-cycle latency), else ltout[i] (zero latency).
REQ-018 Config FSM states IDLE, COMMIT, DONE; cfg_ready = 1 only in IDLE.
REQ-019 IDLE: cfg_valid & cfg_ready & cfg_idx < NUM_LC writes cfg_lut to shadow[cfg_idx]; cfg_idx >= NUM_LC drops the write and pulses cfg_err next cycle.
REQ-020 IDLE + cfg_commit -> COMMIT; a valid write in the same cycle SHALL be included in that commit.
REQ-021 COMMIT: all active LUTs loaded from shadow in one edge -> DONE; DONE: cfg_done = 1 for one cycle -> IDLE.
REQ-022 New LUT contents SHALL first affect ltout in the DONE cycle; no cell SHALL ever see a mix of old and new LUTs across one edge.
REQ-023 cfg_commit outside IDLE SHALL be ignored; cfg_valid outside IDLE SHALL not write.

Reset
REQ-024 rst asynchronously sets shadow and active LUTs to LUT_INIT, q to SR_VAL, FSM to IDLE, cfg_done = cfg_err = 0, cfg_ready = 1 from first edge after release.
REQ-025 rst during COMMIT or DONE aborts the commit; active LUTs revert to LUT_INIT, no cfg_done pulse.

Structure
REQ-026 Package logic_slice40_pkg SHALL hold LUT_W = 16, IDX_W = 5, and the config FSM state enum.
REQ-027 One sub-module lc_cell40 (one LUT, carry majority, register, output mux) SHALL be instantiated NUM_LC times; FSM and shadow/active storage stay in logic_slice40.

Verification
REQ-028 NUM_LC=4, C_ON=1, all LUTs 16'h6996 (XOR4), in1=4'hF, in2=4'h1, carryin=0 -> carryout=1, ltout bits match parity of carry-chain adder sum.
REQ-029 Write shadow[2]=16'hFFFF, no commit -> ltout[2] unchanged; assert cfg_commit -> cfg_done after 2 cycles, ltout[2]=1 in DONE cycle.
REQ-030 cfg_idx=7 with NUM_LC=4 -> cfg_err pulses one cycle, all shadows unchanged.
REQ-031 ce=0, sr=1, SR_VAL=4'b1010 -> lcout=4'b1010 next edge; sr=0, ce=0 -> lcout held.
REQ-032 rst asserted in COMMIT -> active LUTs equal LUT_INIT, cfg_done stays 0, cfg_ready=1 after release.
REQ-033 Write and cfg_commit same cycle -> written LUT active in DONE cycle.
